uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Round-robin arbiter sharing the UART transmit path of top_wrapper among N_REQ clients.
//   Sits between the clients and top_wrapper's i_write / i_write_data / o_write_data_full.
//   It issues one-cycle write pulses, honours the TX FIFO full flag and limits burst length
//   per grant, so no client can starve the others.
// PARAMETERS
//   N_REQ      4   number of requesters (>=1)
//   DATA_W     8   byte width, matches top_wrapper i_write_data
//   MAX_BURST  4   max bytes one owner sends per grant (>=1)
// PORTS
//   i_clk              in   1             system clock, rising edge
//   i_reset            in   1             asynchronous, active-high reset
//   i_req              in   N_REQ         bit k: client k has a byte pending on its data slice
//   i_data             in   N_REQ*DATA_W  client k byte at [k*DATA_W +: DATA_W]
//   i_write_data_full  in   1             from top_wrapper o_write_data_full
//   o_write            out  1             to top_wrapper i_write, one-cycle pulse
//   o_write_data       out  DATA_W        to top_wrapper i_write_data
//   o_ack              out  N_REQ         one-cycle pulse: client k byte accepted
//   o_grant            out  N_REQ         one-hot current owner, 0 when idle
//   o_busy             out  1             1 whenever state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, o_write_data 0, rr pointer 0, burst_cnt 0.
//   All outputs are registered. o_write and o_ack are Moore outputs of state WRITE.
//   States: IDLE, GRANT, WRITE, SETTLE.
//   IDLE: if |i_req, pick the first set bit scanning ptr, ptr+1, ... (mod N_REQ).
//     Next edge: o_grant = onehot(pick), burst_cnt = 0, go to GRANT.
//   GRANT: if !i_req[owner], release and go to IDLE. Otherwise, if i_write_data_full=1,
//     hold in GRANT with no timeout. Otherwise latch o_write_data = owner's slice and go to WRITE.
//   WRITE (exactly 1 cycle): o_write=1 and o_ack[owner]=1. burst_cnt++. Go to SETTLE.
//   SETTLE (1 cycle): gives the client one cycle to update i_req / i_data after o_ack.
//     If burst_cnt==MAX_BURST, release. Otherwise return to GRANT.
//   Release: o_grant=0, ptr=(owner+1) mod N_REQ, go to IDLE.
//   Latency: i_req rises in IDLE at cycle 0 -> o_grant at 1 -> o_write at 2 (full=0).
//     Streaming rate is one byte per 3 cycles.
//   o_write_data holds its value after WRITE until the next capture.
//   Non-owner requests are ignored until the owner releases. Ties resolve by round-robin only.
//   Full is sampled only in GRANT. If full rises during WRITE, the pulse still completes;
//     the FIFO is single-writer and full means it cannot take one more byte.
//   Reset mid-operation: outputs clear immediately. An unfinished byte is neither written
//     nor acked. After reset, arbitration restarts from ptr 0.
//   N_REQ=1: degenerates to a flow-controlled pass-through; ptr stays 0.
// TESTING
//   1. Reset, then i_req=0001, data0=8'hA5, full=0 -> o_grant=0001 at +1; o_write, o_ack=0001,
//      o_write_data=A5 at +2. Drop req after ack -> IDLE, ptr=1.
//   2. MAX_BURST=1, i_req=1111 held, data k=8'h10+k -> o_write_data sequence 10,11,12,13,10.
//      o_ack rotates one-hot.
//   3. Owner granted, full=1 for 20 cycles -> no o_write. o_write appears 1 cycle after full
//      falls, with correct data.
//   4. MAX_BURST=4: client1 sends 6 bytes (31..36) while client2 requests with 8'h5A ->
//      writes 31,32,33,34, then 5A, then 35,36.
//   5. Assert i_reset during WRITE -> o_write/o_ack/o_grant/o_busy drop asynchronously.
//      After release with i_req=1010 -> first grant is client1 (scan starts at ptr 0).
//   6. Client drops i_req while in GRANT -> no o_write, no o_ack, IDLE next cycle, ptr=owner+1.
//   Bench integrates top_wrapper: each o_write byte must appear framed on o_tx in order.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX write port among N_REQ clients.
// Ports: i_clk/i_reset (async, active-high); i_req[k] + i_data slice k = client k pending byte;
// i_write_data_full = TX FIFO full; o_write/o_write_data = FIFO write pulse and byte;
// o_ack[k] = client k byte accepted; o_grant = one-hot owner (0 idle); o_busy = not idle.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    input  logic                    i_write_data_full,
    output logic                    o_write,
    output logic [DATA_W-1:0]       o_write_data,
    output logic [N_REQ-1:0]        o_ack,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, GRANT, WRITE, SETTLE} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d, pick, owner_nxt;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d, owner_data;
    logic [N_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
    logic              write_q, write_d, busy_q, busy_d;
    // Scan downwards so the requester closest to ptr (smallest offset) wins.
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[IW'((int'(ptr_q) + i) % N_REQ)]) pick = IW'((int'(ptr_q) + i) % N_REQ);
        end
    end
    always_comb begin
        owner_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IW'(k)) owner_data = i_data[k*DATA_W +: DATA_W];
        end
    end
    assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    owner_d = pick;
                    grant_d = N_REQ'(1) << pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!i_req[owner_q]) begin
                    grant_d = '0;
                    ptr_d   = owner_nxt;
                    state_d = IDLE;
                end else if (!i_write_data_full) begin
                    data_d  = owner_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CW'(MAX_BURST)) begin
                    grant_d = '0;
                    ptr_d   = owner_nxt;
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase
        write_d = state_d == WRITE;
        ack_d   = write_d ? grant_d : '0;
        busy_d  = state_d != IDLE;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            write_q <= write_d;
            busy_q  <= busy_d;
        end
    end
    assign o_write      = write_q;
    assign o_write_data = data_q;
    assign o_ack        = ack_q;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;
endmodule
